// File: rtl/tv80_bus_responder_if.sv
// tv80 bus bundle between the CPU (master) and a memory/IO target (slave).
//   A       : CPU address bus
//   dout    : CPU write data
//   mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n : CPU strobes, active-low
//   di      : read data returned to the CPU
//   wait_n  : wait request to the CPU, active-low
interface tv80_bus_responder_if;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic [7:0]  di;
    logic        wait_n;

    modport master (
        output A, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        input  di, wait_n
    );

    modport slave (
        input  A, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        output di, wait_n
    );
endinterface

// File: rtl/tv80_bus_responder.sv
// tv80 bus target: a byte array shared by memory space and one mapped IO
// page, with programmable wait states, a write-protected low ROM window and
// a completed-access counter.
//
// Optional feature macro: TV80_BUS_WAIT_EN
//   defined   : MEM_WAIT / IO_WAIT wait states are inserted
//   undefined : no WAIT state, wait_n tied high, every access is zero-wait
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high
//   bus        : tv80 bus (slave modport): A, dout, strobes in; di, wait_n out
//   rom_wr_err : one-cycle pulse on a rejected ROM write
//   access_cnt : completed bus accesses, wraps
//   bd_we      : backdoor write enable
//   bd_addr    : backdoor address
//   bd_wdata   : backdoor write data
//   bd_rdata   : combinational array read at bd_addr
module tv80_bus_responder #(
    parameter int unsigned AW         = 16,
    parameter logic [7:0]  IO_PAGE    = 8'h10,
    parameter int unsigned MEM_WAIT   = 0,
    parameter int unsigned IO_WAIT    = 1,
    parameter int unsigned ROM_SIZE   = 0,
    parameter logic [7:0]  INTACK_VEC = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    tv80_bus_responder_if.slave  bus,
    output logic                 rom_wr_err,
    output logic [15:0]          access_cnt,
    input  logic                 bd_we,
    input  logic [AW-1:0]        bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] ROM_LIM = (AW+1)'(ROM_SIZE);

    // Elaboration-time parameter sanity checks.
    if (MEM_WAIT > 7 || IO_WAIT > 7) begin : g_bad_wait
        $error("tv80_bus_responder: MEM_WAIT/IO_WAIT must be 0..7");
    end
    if (ROM_SIZE > DEPTH) begin : g_bad_rom
        $error("tv80_bus_responder: ROM_SIZE exceeds array depth");
    end

`ifdef TV80_BUS_WAIT_EN
    localparam logic [2:0] MEM_N = 3'(MEM_WAIT);
    localparam logic [2:0] IO_N  = 3'(IO_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACT, S_HOLD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACT, S_HOLD} state_t;
`endif

    typedef enum logic [2:0] {K_MEMRD, K_MEMWR, K_IORD, K_IOWR, K_INTA} kind_t;

    state_t          state;
    kind_t           kind_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      wdata_q;
    logic [7:0]      mem [DEPTH];

    logic            cyc_valid_c;
    kind_t           cyc_kind_c;
    logic [AW-1:0]   cyc_addr_c;
    logic [15:0]     io_addr16_c;
    logic            is_mem_q_c;
    logic            is_write_q_c;
    logic            rom_hit_c;
    logic            strobe_high_c;
    logic            commit_c;

    // Classify the bus cycle presented this clock; INTA first, then memory
    // (which wins over a simultaneous IO strobe), then IO. Refresh never matches.
    always_comb begin
        cyc_valid_c = 1'b0;
        cyc_kind_c  = K_MEMRD;
        io_addr16_c = {IO_PAGE, bus.A[7:0]};
        cyc_addr_c  = AW'(bus.A);
        if (!bus.iorq_n && !bus.m1_n) begin
            cyc_valid_c = 1'b1;
            cyc_kind_c  = K_INTA;
        end else if (!bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n)) begin
            cyc_valid_c = 1'b1;
            cyc_kind_c  = !bus.rd_n ? K_MEMRD : K_MEMWR;
        end else if (!bus.iorq_n && (!bus.rd_n || !bus.wr_n)) begin
            cyc_valid_c = 1'b1;
            cyc_kind_c  = !bus.rd_n ? K_IORD : K_IOWR;
            cyc_addr_c  = AW'(io_addr16_c);
        end
    end

`ifdef TV80_BUS_WAIT_EN
    logic [2:0] wait_cnt;
    logic [2:0] cyc_wait_c;

    // Wait states for the cycle being classified; INTA never waits.
    always_comb begin
        cyc_wait_c = 3'd0;
        case (cyc_kind_c)
            K_MEMRD, K_MEMWR: cyc_wait_c = MEM_N;
            K_IORD,  K_IOWR:  cyc_wait_c = IO_N;
            default:          cyc_wait_c = 3'd0;
        endcase
    end
`else
    assign bus.wait_n = 1'b1;
`endif

    // Attributes of the latched access.
    always_comb begin
        is_mem_q_c    = (kind_q == K_MEMRD) || (kind_q == K_MEMWR);
        is_write_q_c  = (kind_q == K_MEMWR) || (kind_q == K_IOWR);
        rom_hit_c     = (kind_q == K_MEMWR) && ({1'b0, addr_q} < ROM_LIM);
        strobe_high_c = is_mem_q_c ? bus.mreq_n : bus.iorq_n;
        commit_c      = (state == S_ACT) && is_write_q_c && !rom_hit_c && !reset;
    end

    // Access sequencer: IDLE -> [WAIT] -> ACT -> HOLD -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            kind_q     <= K_MEMRD;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            bus.di     <= 8'hFF;
            rom_wr_err <= 1'b0;
            access_cnt <= 16'h0000;
`ifdef TV80_BUS_WAIT_EN
            bus.wait_n <= 1'b1;
            wait_cnt   <= 3'd0;
`endif
        end else begin
            rom_wr_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cyc_valid_c) begin
                        kind_q  <= cyc_kind_c;
                        addr_q  <= cyc_addr_c;
                        wdata_q <= bus.dout;
`ifdef TV80_BUS_WAIT_EN
                        if (cyc_wait_c != 3'd0) begin
                            state      <= S_WAIT;
                            bus.wait_n <= 1'b0;
                            wait_cnt   <= cyc_wait_c;
                        end else begin
                            state <= S_ACT;
                        end
`else
                        state <= S_ACT;
`endif
                    end
                end
`ifdef TV80_BUS_WAIT_EN
                // Strobe dropped mid-wait abandons the access without commit.
                S_WAIT: begin
                    if (strobe_high_c) begin
                        state      <= S_IDLE;
                        bus.wait_n <= 1'b1;
                        wait_cnt   <= 3'd0;
                    end else if (wait_cnt == 3'd1) begin
                        state      <= S_ACT;
                        bus.wait_n <= 1'b1;
                        wait_cnt   <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
`endif
                S_ACT: begin
                    if (kind_q == K_INTA) begin
                        bus.di <= INTACK_VEC;
                    end else if (!is_write_q_c) begin
                        bus.di <= mem[addr_q];
                    end
                    if (rom_hit_c) begin
                        rom_wr_err <= 1'b1;
                    end
                    access_cnt <= access_cnt + 16'd1;
                    state      <= S_HOLD;
                end
                // Wait for the strobe to release so one bus cycle commits once.
                S_HOLD: begin
                    if (strobe_high_c) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array writes; the bus commit is applied last so it wins a collision.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (commit_c) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bd_rdata = mem[bd_addr];

endmodule

// File: tb/tb_tv80_bus_responder.sv
// Directed bench for tv80_bus_responder: drives tv80-style bus cycles and
// checks read data, wait timing, ROM protection and the access counter.
module tb_tv80_bus_responder;

    localparam int unsigned AW = 16;

`ifdef TV80_BUS_WAIT_EN
    localparam int MEM_N_EXP = 2;
    localparam int IO_N_EXP  = 1;
`else
    localparam int MEM_N_EXP = 0;
    localparam int IO_N_EXP  = 0;
`endif

    localparam int K_MEMRD = 0;
    localparam int K_MEMWR = 1;
    localparam int K_IORD  = 2;
    localparam int K_IOWR  = 3;
    localparam int K_INTA  = 4;
    localparam int K_FETCH = 5;
    localparam int K_RFSH  = 6;

    logic           clk;
    logic           reset;
    logic           rom_wr_err;
    logic [15:0]    access_cnt;
    logic           bd_we;
    logic [AW-1:0]  bd_addr;
    logic [7:0]     bd_wdata;
    logic [7:0]     bd_rdata;

    int n_cmp;
    int n_err;
    int exp_cnt;

    tv80_bus_responder_if bus ();

    tv80_bus_responder #(
        .AW         (AW),
        .IO_PAGE    (8'h10),
        .MEM_WAIT   (2),
        .IO_WAIT    (1),
        .ROM_SIZE   (256),
        .INTACK_VEC (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .rom_wr_err (rom_wr_err),
        .access_cnt (access_cnt),
        .bd_we      (bd_we),
        .bd_addr    (bd_addr),
        .bd_wdata   (bd_wdata),
        .bd_rdata   (bd_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobes_idle();
        bus.mreq_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.m1_n   = 1'b1;
        bus.rfsh_n = 1'b1;
    endtask

    task automatic strobes_set(input int kind, input logic [15:0] addr, input logic [7:0] data);
        strobes_idle();
        bus.A    = addr;
        bus.dout = data;
        case (kind)
            K_MEMRD: begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
            K_MEMWR: begin bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
            K_IORD:  begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
            K_IOWR:  begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
            K_INTA:  begin bus.iorq_n = 1'b0; bus.m1_n = 1'b0; end
            K_FETCH: begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.m1_n = 1'b0; end
            K_RFSH:  begin bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; end
            default: ;
        endcase
    endtask

    // One bus cycle: strobes held 6 clocks, then 2 idle clocks.
    task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                             output int waits, output int errs);
        waits = 0;
        errs  = 0;
        @(negedge clk);
        strobes_set(kind, addr, data);
        repeat (6) begin
            @(negedge clk);
            if (!bus.wait_n) waits++;
            if (rom_wr_err)  errs++;
        end
        strobes_idle();
        repeat (2) begin
            @(negedge clk);
            if (!bus.wait_n) waits++;
            if (rom_wr_err)  errs++;
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        bd_addr  = addr;
        bd_wdata = data;
        bd_we    = 1'b1;
        @(negedge clk);
        bd_we    = 1'b0;
    endtask

    task automatic bd_peek(input logic [AW-1:0] addr, output logic [7:0] data);
        bd_addr = addr;
        #1;
        data = bd_rdata;
    endtask

    int         waits;
    int         errs;
    logic [7:0] v;
    logic [7:0] dec_val;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_cnt  = 0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = 8'h00;
        bus.A    = 16'h0000;
        bus.dout = 8'h00;
        strobes_idle();

        // Reset values
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_di", 32'(bus.di), 32'h0FF);
        check("rst_wait_n", 32'(bus.wait_n), 32'h1);
        check("rst_rom_err", 32'(rom_wr_err), 32'h0);
        check("rst_cnt", 32'(access_cnt), 32'h0);
        reset = 1'b0;

        // Preload
        bd_write(16'h0000, 8'h35);
        bd_write(16'h470C, 8'h82);
        bd_write(16'h1234, 8'h5A);
        bd_write(16'h0080, 8'h11);
        bd_write(16'h0400, 8'h44);
        bd_peek(16'h0000, v);
        check("bd_preload", 32'(v), 32'h35);

        // DEC (HL) with HL=470C: fetch, refresh, read, write
        bus_cycle(K_FETCH, 16'h0000, 8'h00, waits, errs);
        exp_cnt++;
        check("fetch_di", 32'(bus.di), 32'h35);
        check("fetch_waits", 32'(waits), 32'(MEM_N_EXP));
        bus_cycle(K_RFSH, 16'h0001, 8'h00, waits, errs);
        check("rfsh_waits", 32'(waits), 32'h0);
        check("rfsh_cnt", 32'(access_cnt), 32'(exp_cnt));
        bus_cycle(K_MEMRD, 16'h470C, 8'h00, waits, errs);
        exp_cnt++;
        check("dec_rd_di", 32'(bus.di), 32'h82);
        dec_val = 8'h82 - 8'h01;
        bus_cycle(K_MEMWR, 16'h470C, dec_val, waits, errs);
        exp_cnt++;
        bd_peek(16'h470C, v);
        check("dec_wr_mem", 32'(v), 32'h81);
        check("dec_cnt", 32'(access_cnt), 32'h3);

        // MEMRD at 1234 with wait timing
        @(negedge clk);
        strobes_set(K_MEMRD, 16'h1234, 8'h00);
`ifdef TV80_BUS_WAIT_EN
        @(negedge clk);
        check("rd_w0_wait_n", 32'(bus.wait_n), 32'h0);
        @(negedge clk);
        check("rd_w1_wait_n", 32'(bus.wait_n), 32'h0);
        check("rd_w1_di_old", 32'(bus.di), 32'h82);
        @(negedge clk);
        check("rd_w2_wait_n", 32'(bus.wait_n), 32'h1);
        check("rd_w2_di_old", 32'(bus.di), 32'h82);
        @(negedge clk);
        check("rd_w3_di", 32'(bus.di), 32'h5A);
`else
        @(negedge clk);
        check("rd_w0_wait_n", 32'(bus.wait_n), 32'h1);
        check("rd_w0_di_old", 32'(bus.di), 32'h82);
        @(negedge clk);
        check("rd_w1_di", 32'(bus.di), 32'h5A);
`endif
        strobes_idle();
        repeat (2) @(negedge clk);
        exp_cnt++;
        check("rd_cnt", 32'(access_cnt), 32'(exp_cnt));

        // IO write then read through the IO page
        bus_cycle(K_IOWR, 16'hAB34, 8'hC3, waits, errs);
        exp_cnt++;
        check("iowr_waits", 32'(waits), 32'(IO_N_EXP));
        bd_peek(16'h1034, v);
        check("iowr_mem", 32'(v), 32'hC3);
        bus_cycle(K_IORD, 16'h0034, 8'h00, waits, errs);
        exp_cnt++;
        check("iord_di", 32'(bus.di), 32'hC3);

        // ROM window
        bus_cycle(K_MEMWR, 16'h0080, 8'h55, waits, errs);
        exp_cnt++;
        check("rom_err_pulses", 32'(errs), 32'h1);
        bd_peek(16'h0080, v);
        check("rom_mem_kept", 32'(v), 32'h11);
        check("rom_cnt", 32'(access_cnt), 32'(exp_cnt));
        bus_cycle(K_MEMWR, 16'h0100, 8'h66, waits, errs);
        exp_cnt++;
        check("ram_err_pulses", 32'(errs), 32'h0);
        bd_peek(16'h0100, v);
        check("ram_mem", 32'(v), 32'h66);

        // Long wr_n with a backdoor overwrite in HOLD: no second commit
        @(negedge clk);
        strobes_set(K_MEMWR, 16'h0200, 8'h77);
        repeat (MEM_N_EXP + 3) @(negedge clk);
        bd_addr  = 16'h0200;
        bd_wdata = 8'hEE;
        bd_we    = 1'b1;
        @(negedge clk);
        bd_we    = 1'b0;
        repeat (2) @(negedge clk);
        strobes_idle();
        repeat (2) @(negedge clk);
        exp_cnt++;
        bd_peek(16'h0200, v);
        check("single_commit_mem", 32'(v), 32'hEE);
        check("single_commit_cnt", 32'(access_cnt), 32'(exp_cnt));

        // Refresh after a write: ignored
        bus_cycle(K_RFSH, 16'h0002, 8'h00, waits, errs);
        check("rfsh2_cnt", 32'(access_cnt), 32'(exp_cnt));

        // INTA: vector, no wait
        bus_cycle(K_INTA, 16'h0000, 8'h00, waits, errs);
        exp_cnt++;
        check("inta_di", 32'(bus.di), 32'h0FF);
        check("inta_waits", 32'(waits), 32'h0);
        check("inta_cnt", 32'(access_cnt), 32'(exp_cnt));

        // Backdoor and bus write collide on the same address: bus wins
        @(negedge clk);
        strobes_set(K_MEMWR, 16'h0300, 8'h5C);
        repeat (MEM_N_EXP + 1) @(negedge clk);
        bd_addr  = 16'h0300;
        bd_wdata = 8'hA7;
        bd_we    = 1'b1;
        @(negedge clk);
        bd_we    = 1'b0;
        strobes_idle();
        repeat (2) @(negedge clk);
        exp_cnt++;
        bd_peek(16'h0300, v);
        check("collide_mem", 32'(v), 32'h5C);

`ifdef TV80_BUS_WAIT_EN
        // Strobe dropped during WAIT: abandoned
        @(negedge clk);
        strobes_set(K_MEMWR, 16'h0400, 8'h99);
        @(negedge clk);
        check("abort_wait_n_lo", 32'(bus.wait_n), 32'h0);
        strobes_idle();
        repeat (3) @(negedge clk);
        check("abort_wait_n_hi", 32'(bus.wait_n), 32'h1);
        bd_peek(16'h0400, v);
        check("abort_mem", 32'(v), 32'h44);
        check("abort_cnt", 32'(access_cnt), 32'(exp_cnt));
`endif

        // Reset during the WAIT (or ACT) of a memory write
        bd_write(16'h2000, 8'h3E);
        @(negedge clk);
        strobes_set(K_MEMWR, 16'h2000, 8'hD1);
        @(negedge clk);
`ifdef TV80_BUS_WAIT_EN
        check("rstw_wait_n_lo", 32'(bus.wait_n), 32'h0);
`endif
        reset = 1'b1;
        #1;
        check("rstw_wait_n", 32'(bus.wait_n), 32'h1);
        check("rstw_di", 32'(bus.di), 32'h0FF);
        check("rstw_cnt", 32'(access_cnt), 32'h0);
        @(negedge clk);
        strobes_idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bd_peek(16'h2000, v);
        check("rstw_mem", 32'(v), 32'h3E);
        check("rstw_cnt_after", 32'(access_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tv80_bus_responder.md
Name: tv80_bus_responder

Overview:
- Synchronous memory/IO slave that answers the tv80s bus (mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n), i.e. the target end of the CPU's bus cycles.
- Holds a byte array shared by memory space and a mapped IO page.
- Inserts programmable wait states, write-protects a low ROM window and counts completed accesses.
- Replaces ad-hoc bench memory models; also used as on-chip RAM/IO in FPGA builds.

Parameters:
- AW, 16, memory address width; array depth 2^AW bytes.
- IO_PAGE, 8'h10, upper address byte for IO accesses; IO address = {IO_PAGE, A[7:0]}, truncated to AW.
- MEM_WAIT, 0, wait states (0-7) inserted on memory read/write cycles.
- IO_WAIT, 1, wait states (0-7) inserted on IO read/write cycles.
- ROM_SIZE, 0, bytes at address 0 that reject bus writes (0 = no ROM).
- INTACK_VEC, 8'hFF, byte driven during interrupt acknowledge.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- A  in  16  CPU address bus.
- dout  in  8  CPU write data.
- mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  CPU strobes, active-low.
- di  out  8  read data to CPU, registered.
- wait_n  out  1  wait request to CPU, active-low, registered.
- rom_wr_err  out  1  one-cycle pulse on a rejected ROM write.
- access_cnt  out  16  completed bus accesses, wraps 16'hFFFF -> 0.
- bd_we  in  1  backdoor write enable (bench preload).
- bd_addr  in  AW  backdoor address.
- bd_wdata  in  8  backdoor write data.
- bd_rdata  out  8  combinational array read at bd_addr.

Behaviour:
- Reset (async): state=IDLE, di=8'hFF, wait_n=1, rom_wr_err=0, access_cnt=0, wait counter=0. Array contents are NOT cleared. A reset mid-access abandons it; a pending write is not committed.
- Cycle classification, sampled each rising edge in IDLE:
  - MEMRD: mreq_n=0, rfsh_n=1, rd_n=0.
  - MEMWR: mreq_n=0, rfsh_n=1, wr_n=0.
  - IORD / IOWR: iorq_n=0, m1_n=1, rd_n or wr_n low.
  - INTA: iorq_n=0, m1_n=0.
  - Refresh (rfsh_n=0) is ignored: no array access, no count, no wait.
- States:
  - IDLE -> WAIT when a classified cycle has wait count N>0 (N = MEM_WAIT or IO_WAIT).
  - IDLE -> ACT when N=0, or for INTA (INTA never waits).
  - WAIT: wait_n=0; counter decrements each clock; at counter=1 -> ACT (exactly N clocks with wait_n low).
  - ACT: wait_n=1. Reads load di from the array (INTA loads INTACK_VEC). Writes commit dout exactly once. access_cnt increments once. -> HOLD.
  - HOLD: remains until the qualifying strobe (mreq_n or iorq_n) is high, then -> IDLE. No further writes or counts, even if wr_n stays low for several clocks.
- Read latency: di valid on the clock edge ending ACT. di holds its value until the next read; it is not forced to 8'hFF between reads.
- Writes with address < ROM_SIZE (memory space only): array unchanged, rom_wr_err pulses for 1 clock in ACT, access_cnt still increments.
- Backdoor: bd_we writes bd_wdata on the rising edge. If it hits the same address in the same cycle as a bus write commit, the bus write wins.
- Strobes deasserted during WAIT (protocol violation): return to IDLE, wait_n=1, no commit, no count.
- Simultaneous mreq_n=0 and iorq_n=0 outside INTA: memory takes priority.

Optional Feature:
- TV80_BUS_WAIT_EN:
  - Defined: wait states are inserted per MEM_WAIT/IO_WAIT as above.
  - Undefined: WAIT state is not built, wait_n is tied to 1, and every access goes IDLE -> ACT with N treated as 0. All other behaviour is unchanged.

Test Plan:
- Preload [0000]=35h, [470C]=82h via backdoor, MEM_WAIT=0. CPU with HL=470Ch executes DEC (HL) -> [470C]=81h, PC=0001, access_cnt=3 (fetch, read, write), wait_n never low.
- MEM_WAIT=2, macro defined: one MEMRD at 1234h holding 5Ah -> wait_n low exactly 2 clocks, di=5Ah one clock after wait_n returns high.
- IOWR to port 34h with data C3h, IO_PAGE=10h -> [1034]=C3h. IORD port 34h -> di=C3h.
- ROM_SIZE=100h: MEMWR 55h to 0080h -> [0080] unchanged, rom_wr_err pulses once. MEMWR to 0100h -> written.
- wr_n held low 4 clocks, refresh cycle interleaved, INTA cycle -> single commit, refresh not counted, INTA di=FFh with no wait.
- Reset asserted during WAIT of a MEMWR -> wait_n=1 and di=FFh immediately, target byte unchanged, access_cnt=0.
